lif_neuron_scheduler: RTL and testbench
=======================================

// Module: lif_neuron_scheduler
// PURPOSE
//  Time-multiplexes one mem_potential_acc datapath across N_NEURONS LIF neurons.
//  Per timestep: fetches sum_wx per neuron from the synapse block (valid/req handshake),
//  forms beta*u by shift-leak, runs accumulate/reset, stores u and spike flag.
//  Sits between the synapse summation stage and the spike output register of the layer.
// PARAMETERS
//  n_stage    6  datapath width W = n_stage+2 (8), matches mem_potential_acc
//  N_NEURONS  4  neurons sharing the datapath; IDXW = clog2(N_NEURONS), min 1
// PORTS
//  clk         in   1     clock; all state on rising edge
//  reset       in   1     asynchronous, active-high reset
//  start       in   1     pulse: begin one timestep; ignored while busy=1
//  theta       in   W     firing threshold, signed, held stable while busy
//  beta_shift  in   3     leak: beta_u = u - (u >>> beta_shift); 0 => beta_u = 0
//  wx_req      out  1     requesting sum_wx for neuron wx_idx
//  wx_idx      out  IDXW  neuron index being requested
//  wx_valid    in   1     sum_wx valid; handshake = wx_req & wx_valid
//  sum_wx      in   W     signed weighted input sum for neuron wx_idx
//  spike_out   out  N     spike_out[i] = spike flag of neuron i (last computed)
//  u_mon       out  W     potential written in the most recent ACC cycle
//  busy        out  1     timestep in progress
//  done        out  1     one-cycle pulse: timestep complete
// BEHAVIOUR
//  Reset (async): state IDLE; u[i]=0, spike[i]=0, wx_idx=0, u_mon=0; wx_req/busy/done=0.
//  FSM: IDLE -start-> REQ -handshake-> ACC -(idx<N-1)-> REQ (idx+1)
//                                          ACC -(idx==N-1)-> DONE -> IDLE
//  IDLE: busy=0. start=1 => idx=0, busy=1, go REQ.
//  REQ: wx_req=1, wx_idx=idx; waits indefinitely; on handshake, sum_wx -> wx_reg.
//   wx_valid while wx_req=0 is ignored.
//  ACC: datapath inputs beta_u(u[idx]), wx_reg, minus_teta=-theta (2's compl, W bits),
//   was_spike=spike[idx]. End of cycle: u[idx]<=u_out, u_mon<=u_out,
//   spike[idx] <= ($signed(u_out) >= $signed(theta)).
//  DONE: done=1 one cycle, busy=0 next cycle; start in DONE is ignored.
//  Arithmetic: all W-bit two's complement, wrap-around, no saturation (datapath truncates).
//  Shift: arithmetic right shift; beta_shift >= W gives u>>>.. = sign fill.
//  Latency, zero stall: start sampled at edge 0; handshake edge 2i+1, write edge 2i+2;
//   done high after edge 2N, low after edge 2N+1 (N=4: done in cycle 8-9).
//  Stall of k cycles on any neuron delays all later events by k.
//  Reset mid-step: immediate abort, all state cleared, no done pulse.
//  spike_out updates per neuron as written (mixed old/new while busy); read after done.
// STRUCTURE
//  Shared package/include: FSM state localparams (IDLE, REQ, ACC, DONE), W, IDXW.
//  Sub-module: mem_potential_acc #(n_stage), existing, instantiated once.
//  Local: u/spike register arrays, wx_reg, idx counter, shift-leak logic (no extra module).
// TESTING (n_stage=6, N_NEURONS=4, theta=20, beta_shift=1)
//  Reset: assert reset mid-REQ -> wx_req=busy=done=0, spike_out=0, u_mon=0 at once.
//  Single step, wx_valid=1, sum_wx=10 -> u[i]=10, spike_out=0000, done after edge 8.
//  sum_wx=16 each step: step1 u=16, no spike; step2 u=24, spike=1;
//   step3 u=24-12+16-20=8, spike=0.
//  Stall: wx_valid low 5 cycles at wx_idx=2 -> wx_req held, idx=2; done 5 cycles late.
//  Wrap: u=0, sum_wx=127 -> u=127, spike=1; next step 127-63+127-20=171 -> wraps to -85,
//   spike=0.
//  start pulsed during busy and in DONE -> ignored: exactly one done pulse, idx not restarted.

Source files
------------

// File: rtl/lif_neuron_scheduler_pkg.sv
// Shared definitions for the LIF neuron scheduler: FSM states and default sizing.
package lif_neuron_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Index width for n neurons, never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int N_STAGE_DEF   = 6;
  localparam int W_DEF         = N_STAGE_DEF + 2;
  localparam int N_NEURONS_DEF = 4;
  localparam int IDXW_DEF      = idx_width(N_NEURONS_DEF);

endpackage

// File: rtl/mem_potential_acc.sv
// Membrane potential accumulator: u_out = beta_u + wx, minus theta if the neuron
// spiked last time. Plain W-bit wrap-around arithmetic, no saturation.
module mem_potential_acc #(
  parameter int  n_stage = 6,
  localparam int W       = n_stage + 2
) (
  input  logic [W-1:0] beta_u,
  input  logic [W-1:0] wx,
  input  logic [W-1:0] minus_teta,
  input  logic         was_spike,
  output logic [W-1:0] u_out
);

  // Accumulate leaked potential and input; apply reset-by-subtraction after a spike.
  always_comb begin
    u_out = beta_u + wx;
    if (was_spike) begin
      u_out = beta_u + wx + minus_teta;
    end else begin
      u_out = beta_u + wx;
    end
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes one mem_potential_acc across N_NEURONS LIF neurons. Each
// timestep fetches sum_wx per neuron over a req/valid handshake, applies
// shift-leak, accumulates, and stores the new potential and spike flag.
module lif_neuron_scheduler
  import lif_neuron_scheduler_pkg::*;
#(
  parameter int  n_stage   = N_STAGE_DEF,
  parameter int  N_NEURONS = N_NEURONS_DEF,
  localparam int W         = n_stage + 2,
  localparam int IDXW      = idx_width(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W-1:0]         theta,
  input  logic [2:0]           beta_shift,
  output logic                 wx_req,
  output logic [IDXW-1:0]      wx_idx,
  input  logic                 wx_valid,
  input  logic [W-1:0]         sum_wx,
  output logic [N_NEURONS-1:0] spike_out,
  output logic [W-1:0]         u_mon,
  output logic                 busy,
  output logic                 done
);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [IDXW-1:0]       idx_r;
  logic signed [W-1:0]   u_r [N_NEURONS];
  logic [N_NEURONS-1:0]  spike_r;
  logic [W-1:0]          wx_r;
  logic [W-1:0]          u_mon_r;

  logic                  last_idx_s;
  logic                  handshake_s;
  logic signed [W-1:0]   u_cur_s;
  logic [W-1:0]          beta_u_s;
  logic [W-1:0]          minus_theta_s;
  logic [W-1:0]          u_out_s;
  logic                  spike_nxt_s;
  logic                  wx_req_s;
  logic                  busy_s;
  logic                  done_s;

  assign last_idx_s  = (idx_r == IDXW'(N_NEURONS - 1));
  assign handshake_s = (state_r == REQ) && wx_valid;

  // Shift-leak: beta*u approximated as u - (u >>> beta_shift); shift 0 leaks everything.
  assign u_cur_s       = u_r[idx_r];
  assign beta_u_s      = u_cur_s - (u_cur_s >>> beta_shift);
  assign minus_theta_s = {W{1'b0}} - theta;
  assign spike_nxt_s   = ($signed(u_out_s) >= $signed(theta));

  mem_potential_acc #(
    .n_stage(n_stage)
  ) u_acc (
    .beta_u    (beta_u_s),
    .wx        (wx_r),
    .minus_teta(minus_theta_s),
    .was_spike (spike_r[idx_r]),
    .u_out     (u_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: one REQ/ACC pair per neuron, then a single DONE cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = REQ;
        else       state_nxt_s = IDLE;
      end
      REQ: begin
        if (wx_valid) state_nxt_s = ACC;
        else          state_nxt_s = REQ;
      end
      ACC: begin
        if (last_idx_s) state_nxt_s = DONE;
        else            state_nxt_s = REQ;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only so they clear at once on reset.
  always_comb begin
    wx_req_s = 1'b0;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      REQ: begin
        wx_req_s = 1'b1;
        busy_s   = 1'b1;
      end
      ACC: begin
        busy_s = 1'b1;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Neuron index counter: cleared on an accepted start, advanced after each ACC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r <= '0;
    end else if ((state_r == IDLE) && start) begin
      idx_r <= '0;
    end else if ((state_r == ACC) && !last_idx_s) begin
      idx_r <= idx_r + IDXW'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Capture sum_wx on the handshake so the ACC cycle works from a stable operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wx_r <= '0;
    end else if (handshake_s) begin
      wx_r <= sum_wx;
    end else begin
      wx_r <= wx_r;
    end
  end

  // Potential, spike flag and monitor write-back for the neuron being accumulated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        u_r[i] <= '0;
      end
      spike_r <= '0;
      u_mon_r <= '0;
    end else if (state_r == ACC) begin
      u_r[idx_r]     <= u_out_s;
      spike_r[idx_r] <= spike_nxt_s;
      u_mon_r        <= u_out_s;
    end
  end

  assign wx_req    = wx_req_s;
  assign wx_idx    = idx_r;
  assign busy      = busy_s;
  assign done      = done_s;
  assign spike_out = spike_r;
  assign u_mon     = u_mon_r;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Self-checking bench for lif_neuron_scheduler: directed and random timesteps
// compared against an arithmetic LIF reference model.
module tb_lif_neuron_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] theta;
  logic [2:0]   beta_shift;
  logic         wx_req;
  logic [1:0]   wx_idx;
  logic         wx_valid;
  logic [W-1:0] sum_wx;
  logic [N-1:0] spike_out;
  logic [W-1:0] u_mon;
  logic         busy;
  logic         done;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int m_u[N];
  bit m_spk[N];
  int m_theta;
  int m_shift;

  lif_neuron_scheduler #(.n_stage(6), .N_NEURONS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .theta(theta), .beta_shift(beta_shift),
    .wx_req(wx_req), .wx_idx(wx_idx), .wx_valid(wx_valid), .sum_wx(sum_wx),
    .spike_out(spike_out), .u_mon(u_mon), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int wrap8(input int x);
    int y;
    y = x & 255;
    if (y > 127) y = y - 256;
    return y;
  endfunction

  // floor(u / 2^s), i.e. what an arithmetic shift means numerically
  function automatic int floor_div_pow2(input int u, input int s);
    int d;
    d = 1 << s;
    if (u >= 0) return u / d;
    else return -((-u + d - 1) / d);
  endfunction

  task automatic model_update(input int n, input int wx);
    int v;
    v = (m_u[n] - floor_div_pow2(m_u[n], m_shift)) + wx - (m_spk[n] ? m_theta : 0);
    m_u[n]   = wrap8(v);
    m_spk[n] = (m_u[n] >= m_theta);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_u[i]   = 0;
      m_spk[i] = 1'b0;
    end
  endtask

  function automatic logic [N-1:0] model_spikes();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_spk[i];
    return v;
  endfunction

  task automatic set_params(input int th, input int sh);
    m_theta    = th;
    m_shift    = sh;
    theta      = 8'(th);
    beta_shift = 3'(sh);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_wx_req"}, wx_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_spike"}, spike_out, 0);
    chk({tag, "_u_mon"}, u_mon, 0);
    chk({tag, "_wx_idx"}, wx_idx, 0);
  endtask

  // Apply reset between timesteps and check outputs clear immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    wx_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    #1;
    check_cleared(tag);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One timestep: answer requests with wx_vals, optionally stalling one neuron,
  // poking start while busy, and toggling wx_valid noise while not requested.
  task automatic run_step(input int wx_vals[N], input int stall_n, input int stall_len,
                          input bit poke, input bit noise);
    int e;
    int served;
    int stall_left;
    int pending;
    int wr_n;
    bit seen_done;
    served     = 0;
    stall_left = stall_len;
    pending    = -1;
    wr_n       = -1;
    seen_done  = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    wx_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    e = 0;
    while (e < 300) begin
      if (wr_n >= 0) begin
        chk("u_mon", $signed(u_mon), m_u[wr_n]);
        chk("spike_bit", spike_out[wr_n], m_spk[wr_n]);
        wr_n = -1;
      end
      if (pending >= 0) begin
        chk("acc_no_req", wx_req, 0);
        model_update(pending, wx_vals[pending]);
        wr_n    = pending;
        pending = -1;
      end
      if (done) begin
        chk("done_edge", e, 2 * N + stall_len);
        chk("done_spikes", spike_out, model_spikes());
        seen_done = 1'b1;
        break;
      end
      chk("busy", busy, 1);
      if (wx_req) begin
        chk("wx_idx", wx_idx, served);
        if (served == stall_n && stall_left > 0) begin
          wx_valid   = 1'b0;
          sum_wx     = 8'($urandom);
          stall_left = stall_left - 1;
        end else begin
          wx_valid = 1'b1;
          sum_wx   = 8'(wx_vals[served]);
          pending  = served;
          served   = served + 1;
        end
      end else begin
        wx_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sum_wx   = 8'($urandom);
      end
      start = (poke && (e == 3 || e == 5)) ? 1'b1 : 1'b0;
      @(negedge clk);
      e++;
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    wx_valid = 1'b0;
    start    = poke;
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("stay_idle", busy, 0);
    chk("stay_idle_req", wx_req, 0);
  endtask

  initial begin
    int v[N];
    reset    = 1'b1;
    start    = 1'b0;
    wx_valid = 1'b0;
    sum_wx   = '0;
    set_params(20, 1);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    // Single step, constant input 10
    for (int i = 0; i < N; i++) v[i] = 10;
    run_step(v, -1, 0, 1'b0, 1'b0);
    chk("step10_spikes", spike_out, 0);

    // Three steps of 16: 16, 24 (spike), 8
    do_reset("rst_b");
    for (int i = 0; i < N; i++) v[i] = 16;
    run_step(v, -1, 0, 1'b0, 1'b0);
    chk("s16_1_spikes", spike_out, 0);
    run_step(v, -1, 0, 1'b0, 1'b0);
    chk("s16_2_spikes", spike_out, 4'b1111);
    run_step(v, -1, 0, 1'b0, 1'b1);
    chk("s16_3_spikes", spike_out, 0);
    chk("s16_3_u", $signed(u_mon), 8);

    // Stall of 5 cycles on neuron 2
    run_step(v, 2, 5, 1'b0, 1'b1);

    // Wrap-around: 127 then 127 -> -85
    do_reset("rst_w");
    for (int i = 0; i < N; i++) v[i] = 127;
    run_step(v, -1, 0, 1'b0, 1'b0);
    chk("wrap1_spikes", spike_out, 4'b1111);
    run_step(v, -1, 0, 1'b0, 1'b0);
    chk("wrap2_u", $signed(u_mon), -85);
    chk("wrap2_spikes", spike_out, 0);

    // start pulsed while busy and in DONE
    for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 60);
    run_step(v, -1, 0, 1'b1, 1'b1);

    // Randomized timesteps
    for (int s = 0; s < 20; s++) begin
      set_params($urandom_range(0, 90) - 30, $urandom_range(0, 7));
      for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 255) - 128;
      run_step(v, $urandom_range(0, N - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset in the middle of a REQ wait
    set_params(20, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreq_req", wx_req, 1);
    reset = 1'b1;
    #1;
    check_cleared("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("post_rst_idle", busy, 0);

    // Fresh step after abort
    for (int i = 0; i < N; i++) v[i] = 5;
    run_step(v, -1, 0, 1'b0, 1'b0);
    chk("post_rst_u", $signed(u_mon), 5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
